mem_controller: RTL and testbench

Sequencing and arbitration front-end for the 512-byte data-path RAM. Shares the single RAM port between the instruction-fetch unit (IF) and the load/store unit (DM). Drives the RAM enable/moc handshake with registered outputs and splits doubleword accesses into two word beats. Rejects misaligned requests, and errors out any access whose moc never arrives.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_rr_arbiter.sv | 36 +++
 rtl/mem_controller.sv | 202 ++++++++++++++++++++
 tb/tb_mem_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-path RAM front-end: size codes, FSM states,
// requester IDs and the alignment/extension helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE       = 2'd0,
    HALFWORD   = 2'd1,
    WORD       = 2'd2,
    DOUBLEWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  function automatic logic misaligned(input size_e len, input logic [1:0] lo);
    case (len)
      HALFWORD:         return lo[0];
      WORD, DOUBLEWORD: return lo != 2'b00;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] zext(input size_e len, input logic [31:0] d);
    case (len)
      BYTE:     return {24'd0, d[7:0]};
      HALFWORD: return {16'd0, d[15:0]};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between IF and DM; the last-grant register
// moves only when the controller actually takes a grant.
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    req_if_i,
  input  logic    req_dm_i,
  input  logic    take_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_q;

  always_comb begin
    gnt_valid_o = req_if_i | req_dm_i;
    if (req_if_i && req_dm_i) begin
      gnt_id_o = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_dm_i) begin
      gnt_id_o = REQ_DM;
    end else begin
      gnt_id_o = REQ_IF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= REQ_IF;
    end else if (take_i && gnt_valid_o) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Shares the single RAM port between IF and DM, sequences the enable/moc
// handshake and splits doublewords into two word beats.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [1:0]        dm_len,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [63:0]       dm_rdata,
  output logic              ram_enable,
  output logic              ram_read_write,
  output logic [1:0]        ram_data_length,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out,
  input  logic              ram_moc
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q;
  req_id_e             id_q;
  logic                rw_q;
  size_e               len_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wlo_q;
  logic                beat_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [63:0]         rdata_q;

  logic                ram_enable_q, ram_rw_q;
  size_e               ram_len_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [31:0]         ram_din_q;
  logic                if_ack_q, if_err_q, dm_ack_q, dm_err_q;
  logic [31:0]         if_rdata_q;
  logic [63:0]         dm_rdata_q;

  logic                gnt_valid;
  req_id_e             gnt_id;
  logic                sel_rw, mis;
  size_e               sel_len;
  logic [ADDR_W-1:0]   sel_addr;
  logic [63:0]         sel_wdata;
  logic                fin, fin_err;
  req_id_e             fin_id;
  logic [63:0]         fin_data;

  mem_rr_arbiter u_arb (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_if_i    (if_req),
    .req_dm_i    (dm_req),
    .take_i      (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Completion (ack/err/data) is decided here so the FSM can register it once.
  always_comb begin
    sel_rw    = 1'b1;
    sel_len   = WORD;
    sel_addr  = if_addr;
    sel_wdata = '0;
    if (gnt_id == REQ_DM) begin
      sel_rw    = dm_rw;
      sel_len   = size_e'(dm_len);
      sel_addr  = dm_addr;
      sel_wdata = dm_wdata;
    end
    mis = misaligned(sel_len, sel_addr[1:0]);

    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_id   = id_q;
    fin_data = '0;
    case (state_q)
      ST_IDLE: if (gnt_valid && mis) begin
        fin     = 1'b1;
        fin_err = 1'b1;
        fin_id  = gnt_id;
      end
      ST_ACCESS: if (!ram_moc && cnt_q == CNT_W'(TIMEOUT - 1)) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
      ST_RELEASE: if (!ram_moc && !(len_q == DOUBLEWORD && !beat_q)) begin
        fin      = 1'b1;
        fin_data = rw_q ? rdata_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= REQ_IF;
      rw_q         <= 1'b1;
      len_q        <= BYTE;
      addr_q       <= '0;
      wlo_q        <= '0;
      beat_q       <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      ram_enable_q <= 1'b0;
      ram_rw_q     <= 1'b1;
      ram_len_q    <= BYTE;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      dm_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if_ack_q <= fin && (fin_id == REQ_IF);
      if_err_q <= fin && (fin_id == REQ_IF) && fin_err;
      dm_ack_q <= fin && (fin_id == REQ_DM);
      dm_err_q <= fin && (fin_id == REQ_DM) && fin_err;
      if (fin && fin_id == REQ_IF) if_rdata_q <= fin_data[31:0];
      if (fin && fin_id == REQ_DM) dm_rdata_q <= fin_data;

      unique case (state_q)
        ST_IDLE: if (gnt_valid) begin
          id_q    <= gnt_id;
          rw_q    <= sel_rw;
          len_q   <= sel_len;
          addr_q  <= sel_addr;
          wlo_q   <= sel_wdata[31:0];
          beat_q  <= 1'b0;
          cnt_q   <= '0;
          rdata_q <= '0;
          if (mis) begin
            state_q <= ST_ACK;
          end else begin
            state_q      <= ST_ACCESS;
            ram_enable_q <= 1'b1;
            ram_rw_q     <= sel_rw;
            ram_len_q    <= (sel_len == DOUBLEWORD) ? WORD : sel_len;
            ram_addr_q   <= sel_addr;
            ram_din_q    <= (sel_len == DOUBLEWORD) ? sel_wdata[63:32] : sel_wdata[31:0];
          end
        end
        ST_ACCESS: begin
          if (ram_moc) begin
            // Shifting in each beat yields {beat0, beat1} for doublewords.
            rdata_q      <= {rdata_q[31:0], zext(len_q, ram_data_out)};
            cnt_q        <= '0;
            ram_enable_q <= 1'b0;
            state_q      <= ST_RELEASE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            ram_enable_q <= 1'b0;
            state_q      <= ST_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: if (!ram_moc) begin
          if (len_q == DOUBLEWORD && !beat_q) begin
            beat_q       <= 1'b1;
            ram_enable_q <= 1'b1;
            ram_addr_q   <= addr_q + ADDR_W'(4);
            ram_din_q    <= wlo_q;
            state_q      <= ST_ACCESS;
          end else begin
            state_q <= ST_ACK;
          end
        end
        ST_ACK: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_enable      = ram_enable_q;
  assign ram_read_write  = ram_rw_q;
  assign ram_data_length = ram_len_q;
  assign ram_address     = ram_addr_q;
  assign ram_data_in     = ram_din_q;
  assign if_ack          = if_ack_q;
  assign if_err          = if_err_q;
  assign if_rdata        = if_rdata_q;
  assign dm_ack          = dm_ack_q;
  assign dm_err          = dm_err_q;
  assign dm_rdata        = dm_rdata_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a little-endian byte RAM model that
// answers moc in the same cycle as enable (switchable off for timeouts).
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, if_err;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_rw, dm_ack, dm_err;
  logic [1:0]  dm_len;
  logic [8:0]  dm_addr;
  logic [63:0] dm_wdata, dm_rdata;
  logic        ram_enable, ram_read_write, ram_moc;
  logic [1:0]  ram_data_length;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  int vectors = 0;
  int miscompares = 0;

  logic       moc_en;
  logic [7:0] mem [512];
  logic [8:0] a1, a2, a3;
  logic       en_prev = 1'b0;
  int         rises = 0;
  int         collisions = 0;
  logic [8:0] beat_log [64];
  int         beat_n = 0;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_len(dm_len), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .ram_enable(ram_enable), .ram_read_write(ram_read_write), .ram_data_length(ram_data_length),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_moc(ram_moc)
  );

  assign ram_moc = moc_en & ram_enable;
  assign a1 = ram_address + 9'd1;
  assign a2 = ram_address + 9'd2;
  assign a3 = ram_address + 9'd3;

  always_comb begin
    case (ram_data_length)
      2'd0:    ram_data_out = {24'd0, mem[ram_address]};
      2'd1:    ram_data_out = {16'd0, mem[a1], mem[ram_address]};
      default: ram_data_out = {mem[a3], mem[a2], mem[a1], mem[ram_address]};
    endcase
  end

  always @(posedge clk) begin
    en_prev <= ram_enable;
    if (ram_enable && !en_prev) rises <= rises + 1;
    if (ram_enable && ram_moc) begin
      beat_log[beat_n[5:0]] <= ram_address;
      beat_n <= beat_n + 1;
      if (!ram_read_write) begin
        mem[ram_address] <= ram_data_in[7:0];
        if (ram_data_length >= 2'd1) mem[a1] <= ram_data_in[15:8];
        if (ram_data_length >= 2'd2) begin
          mem[a2] <= ram_data_in[23:16];
          mem[a3] <= ram_data_in[31:24];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_ack && dm_ack) collisions <= collisions + 1;
  end

  task automatic dm_op(input logic rw, input logic [1:0] len, input logic [8:0] addr,
                       input logic [63:0] wd, output logic [63:0] rd, output logic er,
                       output int lat, output logic en_at_ack);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; en_at_ack = 1'b0; lat = 0;
    @(negedge clk);
    dm_req = 1'b1; dm_rw = rw; dm_len = len; dm_addr = addr; dm_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (dm_ack) begin
        rd = dm_rdata; er = dm_err; en_at_ack = ram_enable; got = 1'b1;
        break;
      end
    end
    dm_req = 1'b0;
    if (!got) lat = -1;
  endtask

  task automatic if_op(input logic [8:0] addr, output logic [31:0] rd, output logic er,
                       output int lat);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (if_ack) begin
        rd = if_rdata; er = if_err; got = 1'b1;
        break;
      end
    end
    if_req = 1'b0;
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    logic [48:0] got, exp;
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);
    got = {ram_enable, ram_read_write, ram_data_length, ram_address, ram_data_in,
           if_ack, if_err, dm_ack, dm_err};
    exp = {1'b0, 1'b1, 2'd0, 9'd0, 32'd0, 4'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL reset_ctrl: got %h expected %h", got, exp);
    end
    vectors++;
    if ({if_rdata, dm_rdata} !== 96'd0) begin
      miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    logic [63:0] rd; logic [31:0] ird; logic er, en; int lat;
    dm_op(1'b0, 2'd2, 9'h010, 64'h0000_0000_DEAD_BEEF, rd, er, lat, en);
    vectors++;
    if (lat !== 3 || er !== 1'b0) begin
      miscompares++; $display("FAIL word_write: lat %0d err %b expected 3/0", lat, er);
    end
    if_op(9'h010, ird, er, lat);
    vectors++;
    if (ird !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("FAIL if_read: data %h err %b lat %0d expected deadbeef/0/3", ird, er, lat);
    end
  endtask

  task automatic test_doubleword();
    logic [63:0] rd; logic er, en; int lat, b0;
    b0 = beat_n;
    dm_op(1'b0, 2'd3, 9'h1FC, 64'h1122_3344_5566_7788, rd, er, lat, en);
    vectors++;
    if (lat !== 5 || er !== 1'b0) begin
      miscompares++; $display("FAIL dw_write: lat %0d err %b expected 5/0", lat, er);
    end
    vectors++;
    if (beat_n - b0 !== 2 || beat_log[b0[5:0]] !== 9'h1FC || beat_log[(b0 + 1) & 63] !== 9'h000) begin
      miscompares++;
      $display("FAIL dw_beat_addr: beats %0d addr %h,%h expected 2 1fc,000", beat_n - b0,
               beat_log[b0[5:0]], beat_log[(b0 + 1) & 63]);
    end
    dm_op(1'b1, 2'd3, 9'h1FC, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0 || lat !== 5) begin
      miscompares++;
      $display("FAIL dw_read: data %h err %b lat %0d expected 1122334455667788/0/5", rd, er, lat);
    end
    dm_op(1'b1, 2'd2, 9'h000, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h0000_0000_5566_7788) begin
      miscompares++; $display("FAIL dw_wrap_word: data %h expected 0000000055667788", rd);
    end
  endtask

  task automatic test_sizes();
    logic [63:0] rd; logic er, en; int lat;
    dm_op(1'b0, 2'd2, 9'h020, 64'h0000_0000_1234_5678, rd, er, lat, en);
    dm_op(1'b0, 2'd0, 9'h021, 64'hFFFF_FFFF_FFFF_FFA5, rd, er, lat, en);
    dm_op(1'b1, 2'd2, 9'h020, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h0000_0000_1234_A578 || lat !== 3) begin
      miscompares++; $display("FAIL byte_write: data %h lat %0d expected 000000001234a578/3", rd, lat);
    end
    dm_op(1'b1, 2'd1, 9'h022, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h0000_0000_0000_1234 || er !== 1'b0) begin
      miscompares++; $display("FAIL half_read: data %h err %b expected 1234/0", rd, er);
    end
    dm_op(1'b1, 2'd0, 9'h021, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h0000_0000_0000_00A5) begin
      miscompares++; $display("FAIL byte_read: data %h expected a5", rd);
    end
    dm_op(1'b0, 2'd1, 9'h022, 64'h0000_0000_0000_BEEF, rd, er, lat, en);
    dm_op(1'b1, 2'd2, 9'h020, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h0000_0000_BEEF_A578) begin
      miscompares++; $display("FAIL half_write: data %h expected beefa578", rd);
    end
    dm_op(1'b1, 2'd0, 9'h003, 64'd0, rd, er, lat, en);
    vectors++;
    if (rd !== 64'h55 || er !== 1'b0 || lat !== 3) begin
      miscompares++; $display("FAIL byte_odd_addr: data %h err %b lat %0d expected 55/0/3", rd, er, lat);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic [31:0] ird; logic er, en; int lat, r0;
    r0 = rises;
    dm_op(1'b1, 2'd1, 9'h003, 64'd0, rd, er, lat, en);
    vectors++;
    if (lat !== 1 || er !== 1'b1 || rd !== 64'd0) begin
      miscompares++; $display("FAIL mis_half: lat %0d err %b data %h expected 1/1/0", lat, er, rd);
    end
    if_op(9'h012, ird, er, lat);
    vectors++;
    if (lat !== 1 || er !== 1'b1 || ird !== 32'd0) begin
      miscompares++; $display("FAIL mis_if: lat %0d err %b data %h expected 1/1/0", lat, er, ird);
    end
    dm_op(1'b0, 2'd3, 9'h006, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, en);
    vectors++;
    if (lat !== 1 || er !== 1'b1) begin
      miscompares++; $display("FAIL mis_dw: lat %0d err %b expected 1/1", lat, er);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (rises !== r0) begin
      miscompares++; $display("FAIL mis_no_ram: enable rises %0d expected 0", rises - r0);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] rd; logic er, en; int lat;
    moc_en = 1'b0;
    dm_op(1'b1, 2'd2, 9'h040, 64'd0, rd, er, lat, en);
    vectors++;
    if (lat !== 16 || er !== 1'b1 || rd !== 64'd0 || en !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: lat %0d err %b data %h en %b expected 16/1/0/0", lat, er, rd, en);
    end
    moc_en = 1'b1;
  endtask

  task automatic test_round_robin();
    int order [4];
    int n, c0;
    test_reset();
    c0 = collisions; n = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 9'h010;
    dm_req = 1'b1; dm_rw = 1'b1; dm_len = 2'd2; dm_addr = 9'h020;
    for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
      @(negedge clk);
      if (!if_req) if_req = 1'b1;
      if (!dm_req) dm_req = 1'b1;
      if (if_ack && n < 4) begin order[n] = 0; n++; if_req = 1'b0; end
      if (dm_ack && n < 4) begin order[n] = 1; n++; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    vectors++;
    if (n !== 4) begin
      miscompares++; $display("FAIL rr_count: acks %0d expected 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (k < n && order[k] !== ((k % 2 == 0) ? 1 : 0)) begin
        miscompares++; $display("FAIL rr_order%0d: got %0d expected %0d", k, order[k], (k % 2 == 0) ? 1 : 0);
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (collisions !== c0) begin
      miscompares++; $display("FAIL rr_collision: %0d expected 0", collisions - c0);
    end
  endtask

  task automatic test_reset_abort();
    logic [48:0] got, exp;
    logic [31:0] ird; logic er; int lat, acks;
    moc_en = 1'b0; acks = 0;
    @(negedge clk);
    dm_req = 1'b1; dm_rw = 1'b0; dm_len = 2'd2; dm_addr = 9'h080; dm_wdata = 64'hCAFE_F00D;
    repeat (3) @(negedge clk);
    vectors++;
    if (ram_enable !== 1'b1) begin
      miscompares++; $display("FAIL abort_in_access: enable %b expected 1", ram_enable);
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = {ram_enable, ram_read_write, ram_data_length, ram_address, ram_data_in,
           if_ack, if_err, dm_ack, dm_err};
    exp = {1'b0, 1'b1, 2'd0, 9'd0, 32'd0, 4'd0};
    vectors++;
    if (got !== exp || dm_rdata !== 64'd0 || if_rdata !== 32'd0) begin
      miscompares++; $display("FAIL abort_reset_vals: got %h expected %h", got, exp);
    end
    dm_req = 1'b0; moc_en = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dm_ack) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++; $display("FAIL abort_no_ack: dm_ack seen %0d expected 0", acks);
    end
    if_op(9'h010, ird, er, lat);
    vectors++;
    if (ird !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("FAIL abort_recover: data %h err %b lat %0d expected deadbeef/0/3", ird, er, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; moc_en = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_rw = 1'b1; dm_len = 2'd0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_if_read();
    test_doubleword();
    test_sizes();
    test_misaligned();
    test_timeout();
    test_round_robin();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
